// File: rtl/hxd32_mem_slv.sv
// hxd32_mem_slv: IRAM/DRAM responder for the hxd32 core, plus a host load port.
//
// Ports:
//   clk_i, rst_n_i        clock, asynchronous active-low reset
//   iram_rd_addr_i/_o     fetch byte address / data (1-cycle latency)
//   dram_rd_addr_i/_o     load byte address / data (1-cycle latency)
//   dram_wr_*_i           store byte address, data, byte enables (0 = no write)
//   ld_start_i            pulse: begin host load (ld_sel_i, ld_len_i sampled here)
//   ld_data_i, ld_valid_i host load word stream; accepted when valid & ld_ready_o
//   ld_busy_o, ld_done_o  loader busy, 1-cycle end-of-load pulse
//   ld_sum_o              wrapping sum of accepted words of the current load
//   core_rst_n_o          active-low reset to hxd32, held low while loading
//
// Optional feature: define HXD32_MEM_CHKSUM_EN to build the load checksum adder;
// otherwise ld_sum_o is tied to zero.
//
// Reads are write-first: a read of a word being written in the same cycle returns the
// merged new word. Out-of-range reads return 0 and out-of-range writes are dropped.
// Depths must be powers of two no larger than 65536 (the load counter is 16 bits).
module hxd32_mem_slv #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned IRAM_DEPTH = 1024,
  parameter int unsigned DRAM_DEPTH = 1024
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic [XLEN-1:0] iram_rd_addr_i,
  output logic [XLEN-1:0] iram_rd_data_o,
  input  logic [XLEN-1:0] dram_rd_addr_i,
  output logic [XLEN-1:0] dram_rd_data_o,
  input  logic [XLEN-1:0] dram_wr_addr_i,
  input  logic [XLEN-1:0] dram_wr_data_i,
  input  logic [3:0]      dram_wr_byte_en_i,
  input  logic            ld_start_i,
  input  logic            ld_sel_i,
  input  logic [15:0]     ld_len_i,
  input  logic [XLEN-1:0] ld_data_i,
  input  logic            ld_valid_i,
  output logic            ld_ready_o,
  output logic            ld_busy_o,
  output logic            ld_done_o,
  output logic [XLEN-1:0] ld_sum_o,
  output logic            core_rst_n_o
);

  localparam int unsigned IAW = $clog2(IRAM_DEPTH);
  localparam int unsigned DAW = $clog2(DRAM_DEPTH);

  typedef enum logic [1:0] {StRun, StLoad, StDone} state_e;

  state_e      state_q, state_d;
  logic        ld_sel_q, ld_sel_d;
  logic [15:0] ld_len_q, ld_len_d;
  logic [15:0] ld_cnt_q, ld_cnt_d;
  logic        ld_beat;
  logic        ld_clr;

  // Loader FSM
  always_comb begin
    state_d    = state_q;
    ld_sel_d   = ld_sel_q;
    ld_len_d   = ld_len_q;
    ld_cnt_d   = ld_cnt_q;
    ld_beat    = 1'b0;
    ld_clr     = 1'b0;
    ld_ready_o = 1'b0;
    ld_done_o  = 1'b0;
    unique case (state_q)
      StRun: begin
        if (ld_start_i) begin
          ld_sel_d = ld_sel_i;
          ld_len_d = ld_len_i;
          ld_cnt_d = '0;
          ld_clr   = 1'b1;
          state_d  = (ld_len_i == 16'd0) ? StDone : StLoad;
        end
      end
      StLoad: begin
        ld_ready_o = 1'b1;
        if (ld_valid_i) begin
          ld_beat  = 1'b1;
          ld_cnt_d = ld_cnt_q + 16'd1;
          if (ld_cnt_q == ld_len_q - 16'd1) state_d = StDone;
        end
      end
      StDone: begin
        ld_done_o = 1'b1;
        state_d   = StRun;
      end
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= StRun;
      ld_sel_q <= 1'b0;
      ld_len_q <= '0;
      ld_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      ld_sel_q <= ld_sel_d;
      ld_len_q <= ld_len_d;
      ld_cnt_q <= ld_cnt_d;
    end
  end

  assign ld_busy_o    = (state_q != StRun);
  // Core is held in reset from the cycle after start through DONE.
  assign core_rst_n_o = (state_q == StRun);

  // Address decode: any set bit above the array span means out of range.
  logic           iram_rd_oor, dram_rd_oor, dram_wr_oor;
  logic [IAW-1:0] iram_ridx;
  logic [DAW-1:0] dram_ridx;

  assign iram_rd_oor = |iram_rd_addr_i[XLEN-1:IAW+2];
  assign dram_rd_oor = |dram_rd_addr_i[XLEN-1:DAW+2];
  assign dram_wr_oor = |dram_wr_addr_i[XLEN-1:DAW+2];
  assign iram_ridx   = iram_rd_addr_i[IAW+1:2];
  assign dram_ridx   = dram_rd_addr_i[DAW+1:2];

  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{iram_rd_addr_i[1:0], dram_rd_addr_i[1:0], dram_wr_addr_i[1:0]};

  // Write port selection: the loader owns DRAM writes while in LOAD.
  logic            iram_we;
  logic [IAW-1:0]  iram_widx;
  logic            dram_we;
  logic [DAW-1:0]  dram_widx;
  logic [3:0]      dram_wbe;
  logic [XLEN-1:0] dram_wdata;

  assign iram_we   = ld_beat && !ld_sel_q;
  assign iram_widx = ld_cnt_q[IAW-1:0];

  always_comb begin
    dram_we    = 1'b0;
    dram_widx  = dram_wr_addr_i[DAW+1:2];
    dram_wbe   = dram_wr_byte_en_i;
    dram_wdata = dram_wr_data_i;
    if (ld_beat && ld_sel_q) begin
      dram_we    = 1'b1;
      dram_widx  = ld_cnt_q[DAW-1:0];
      dram_wbe   = 4'hF;
      dram_wdata = ld_data_i;
    end else if (state_q != StLoad && |dram_wr_byte_en_i && !dram_wr_oor) begin
      dram_we = 1'b1;
    end
  end

  // Storage (not reset)
  logic [XLEN-1:0] iram_mem [IRAM_DEPTH];
  logic [XLEN-1:0] dram_mem [DRAM_DEPTH];

  always_ff @(posedge clk_i) begin
    if (iram_we) iram_mem[iram_widx] <= ld_data_i;
  end

  always_ff @(posedge clk_i) begin
    for (int i = 0; i < 4; i++) begin
      if (dram_we && dram_wbe[i]) dram_mem[dram_widx][8*i +: 8] <= dram_wdata[8*i +: 8];
    end
  end

  // Write-first read data
  logic [XLEN-1:0] iram_rd_d, iram_rd_q;
  logic [XLEN-1:0] dram_rd_d, dram_rd_q;

  always_comb begin
    iram_rd_d = '0;
    if (!iram_rd_oor) begin
      iram_rd_d = iram_mem[iram_ridx];
      if (iram_we && iram_widx == iram_ridx) iram_rd_d = ld_data_i;
    end
  end

  always_comb begin
    dram_rd_d = '0;
    if (!dram_rd_oor) begin
      dram_rd_d = dram_mem[dram_ridx];
      if (dram_we && dram_widx == dram_ridx) begin
        for (int i = 0; i < 4; i++) begin
          if (dram_wbe[i]) dram_rd_d[8*i +: 8] = dram_wdata[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      iram_rd_q <= '0;
      dram_rd_q <= '0;
    end else begin
      iram_rd_q <= iram_rd_d;
      dram_rd_q <= dram_rd_d;
    end
  end

  assign iram_rd_data_o = iram_rd_q;
  assign dram_rd_data_o = dram_rd_q;

`ifdef HXD32_MEM_CHKSUM_EN
  logic [XLEN-1:0] ld_sum_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ld_sum_q <= '0;
    end else if (ld_clr) begin
      ld_sum_q <= '0;
    end else if (ld_beat) begin
      ld_sum_q <= ld_sum_q + ld_data_i;
    end
  end

  assign ld_sum_o = ld_sum_q;
`else
  assign ld_sum_o = '0;
`endif

endmodule

// File: tb/tb_hxd32_mem_slv.sv
// Self-checking bench for hxd32_mem_slv: directed scenarios plus randomized traffic,
// checked against a word-array reference model of both memories and the loader.
module tb_hxd32_mem_slv;

  localparam int ID = 1024;
  localparam int DD = 1024;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] iram_rd_addr = '0, iram_rd_data;
  logic [31:0] dram_rd_addr = '0, dram_rd_data;
  logic [31:0] dram_wr_addr = '0, dram_wr_data = '0;
  logic [3:0]  dram_wr_byte_en = '0;
  logic        ld_start = 1'b0, ld_sel = 1'b0;
  logic [15:0] ld_len = '0;
  logic [31:0] ld_data = '0;
  logic        ld_valid = 1'b0;
  logic        ld_ready, ld_busy, ld_done, core_rst_n;
  logic [31:0] ld_sum;

  hxd32_mem_slv dut (
    .clk_i             (clk),
    .rst_n_i           (rst_n),
    .iram_rd_addr_i    (iram_rd_addr),
    .iram_rd_data_o    (iram_rd_data),
    .dram_rd_addr_i    (dram_rd_addr),
    .dram_rd_data_o    (dram_rd_data),
    .dram_wr_addr_i    (dram_wr_addr),
    .dram_wr_data_i    (dram_wr_data),
    .dram_wr_byte_en_i (dram_wr_byte_en),
    .ld_start_i        (ld_start),
    .ld_sel_i          (ld_sel),
    .ld_len_i          (ld_len),
    .ld_data_i         (ld_data),
    .ld_valid_i        (ld_valid),
    .ld_ready_o        (ld_ready),
    .ld_busy_o         (ld_busy),
    .ld_done_o         (ld_done),
    .ld_sum_o          (ld_sum),
    .core_rst_n_o      (core_rst_n)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [31:0] iref [ID];
  logic [31:0] dref [DD];
  bit          iknown [ID];
  bit          dknown [DD];
  bit          loading = 1'b0;
  bit          ld_tgt_m = 1'b0;
  int          ld_len_m = 0;
  int          ld_cnt_m = 0;
  logic [31:0] sum_m = '0;
  bit          warm = 1'b0;
  logic [31:0] word_q [$];

  int n_checks = 0;
  int n_pass = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic logic [31:0] exp_sum();
`ifdef HXD32_MEM_CHKSUM_EN
    return sum_m;
`else
    return 32'h0;
`endif
  endfunction

  function automatic logic [31:0] rand_addr(input int depth);
    int unsigned sel;
    sel = $urandom_range(0, 15);
    if (sel == 0) return $urandom;
    if (sel == 1) return 32'(depth * 4) + 32'($urandom_range(0, 3));
    return 32'($urandom_range(0, depth * 4 - 1));
  endfunction

  function automatic logic [31:0] next_word();
    if (word_q.size() > 0) return word_q.pop_front();
    return $urandom;
  endfunction

  task automatic rand_core();
    iram_rd_addr = rand_addr(ID);
    dram_rd_addr = rand_addr(DD);
    dram_wr_addr = rand_addr(DD);
    dram_wr_data = $urandom;
    dram_wr_byte_en = (warm && $urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
    if ($urandom_range(0, 3) == 0) dram_rd_addr = dram_wr_addr ^ 32'($urandom_range(0, 3));
  endtask

  task automatic quiet();
    iram_rd_addr = '0;
    dram_rd_addr = '0;
    dram_wr_addr = '0;
    dram_wr_data = '0;
    dram_wr_byte_en = '0;
    ld_valid = 1'b0;
    ld_start = 1'b0;
  endtask

  // One clock: apply this cycle's effects to the model, clock, then check read data.
  task automatic tick();
    logic [31:0] exp_i, exp_d;
    bit ck_i, ck_d;
    int idx;
    if (loading && ld_valid) begin
      if (ld_tgt_m) begin
        dref[ld_cnt_m % DD] = ld_data;
        dknown[ld_cnt_m % DD] = 1'b1;
      end else begin
        iref[ld_cnt_m % ID] = ld_data;
        iknown[ld_cnt_m % ID] = 1'b1;
      end
      sum_m += ld_data;
      ld_cnt_m++;
      if (ld_cnt_m == ld_len_m) loading = 1'b0;
    end else if (!loading && dram_wr_byte_en != 4'h0 && dram_wr_addr < 32'(DD * 4)) begin
      idx = int'(dram_wr_addr >> 2);
      for (int b = 0; b < 4; b++) begin
        if (dram_wr_byte_en[b]) dref[idx][8*b +: 8] = dram_wr_data[8*b +: 8];
      end
      if (dram_wr_byte_en == 4'hF) dknown[idx] = 1'b1;
    end
    exp_i = '0;
    ck_i = 1'b1;
    if (iram_rd_addr < 32'(ID * 4)) begin
      exp_i = iref[iram_rd_addr >> 2];
      ck_i = iknown[iram_rd_addr >> 2];
    end
    exp_d = '0;
    ck_d = 1'b1;
    if (dram_rd_addr < 32'(DD * 4)) begin
      exp_d = dref[dram_rd_addr >> 2];
      ck_d = dknown[dram_rd_addr >> 2];
    end
    @(posedge clk);
    #1;
    if (ck_i) check_eq("iram_rd", iram_rd_data, exp_i);
    if (ck_d) check_eq("dram_rd", dram_rd_data, exp_d);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    #2;
    loading = 1'b0;
    sum_m = '0;
    word_q.delete();
    check_eq("rst_iram_rd", iram_rd_data, 32'h0);
    check_eq("rst_dram_rd", dram_rd_data, 32'h0);
    check_eq("rst_ready", 32'(ld_ready), 32'h0);
    check_eq("rst_busy", 32'(ld_busy), 32'h0);
    check_eq("rst_done", 32'(ld_done), 32'h0);
    check_eq("rst_sum", ld_sum, 32'h0);
    check_eq("rst_core_rst_n", 32'(core_rst_n), 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Host load of len words into sel; abort_at >= 0 resets the DUT after that many beats.
  task automatic run_load(input bit sel, input int len, input int vpct, input int abort_at);
    int guard;
    ld_start = 1'b1;
    ld_sel = sel;
    ld_len = 16'(len);
    ld_valid = 1'($urandom_range(0, 1));
    ld_data = $urandom;
    rand_core();
    tick();
    ld_start = 1'b0;
    ld_tgt_m = sel;
    ld_len_m = len;
    ld_cnt_m = 0;
    sum_m = '0;
    loading = (len != 0);
    check_eq("start_busy", 32'(ld_busy), 32'h1);
    check_eq("start_core_rst_n", 32'(core_rst_n), 32'h0);
    check_eq("start_done", 32'(ld_done), 32'(len == 0));
    check_eq("start_ready", 32'(ld_ready), 32'(len != 0));
    guard = 0;
    while (loading) begin
      if (abort_at >= 0 && ld_cnt_m == abort_at) begin
        ld_valid = 1'b0;
        apply_reset();
        return;
      end
      ld_valid = ($urandom_range(0, 99) < vpct) || (guard > 4 * len + 20);
      ld_data = ld_valid ? next_word() : $urandom;
      rand_core();
      tick();
      guard++;
      if (loading) begin
        check_eq("load_ready", 32'(ld_ready), 32'h1);
        check_eq("load_done", 32'(ld_done), 32'h0);
        check_eq("load_core_rst_n", 32'(core_rst_n), 32'h0);
      end
    end
    check_eq("done_pulse", 32'(ld_done), 32'h1);
    check_eq("done_ready", 32'(ld_ready), 32'h0);
    check_eq("done_core_rst_n", 32'(core_rst_n), 32'h0);
    check_eq("done_sum", ld_sum, exp_sum());
    ld_valid = 1'($urandom_range(0, 1));
    ld_data = $urandom;
    rand_core();
    tick();
    check_eq("post_done", 32'(ld_done), 32'h0);
    check_eq("post_core_rst_n", 32'(core_rst_n), 32'h1);
    check_eq("post_busy", 32'(ld_busy), 32'h0);
    check_eq("post_sum", ld_sum, exp_sum());
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      ld_valid = 1'($urandom_range(0, 1));
      ld_data = $urandom;
      rand_core();
      tick();
      check_eq("idle_ready", 32'(ld_ready), 32'h0);
      check_eq("idle_busy", 32'(ld_busy), 32'h0);
    end
  endtask

  initial begin
    logic [31:0] w [4];
    logic [31:0] d2, d3, w0;
    for (int i = 0; i < ID; i++) begin iref[i] = '0; iknown[i] = 1'b0; end
    for (int i = 0; i < DD; i++) begin dref[i] = '0; dknown[i] = 1'b0; end

    repeat (2) @(posedge clk);
    #1;
    apply_reset();

    // Fill both memories; IRAM load is longer than the depth and wraps.
    run_load(1'b0, ID + 6, 80, -1);
    run_load(1'b1, DD, 70, -1);
    warm = 1'b1;
    idle_cycles(40);

    // IRAM len 3, directed data, then fetch 0x8.
    word_q = '{32'h11, 32'h22, 32'h33};
    run_load(1'b0, 3, 100, -1);
    quiet();
    iram_rd_addr = 32'h8;
    tick();
    check_eq("fetch_0x8", iram_rd_data, 32'h33);

    // Byte-enable store merge.
    quiet();
    dram_wr_addr = 32'h4;
    dram_wr_data = 32'hAABBCCDD;
    dram_wr_byte_en = 4'hF;
    tick();
    dram_wr_data = 32'h11223344;
    dram_wr_byte_en = 4'b0101;
    tick();
    quiet();
    dram_rd_addr = 32'h4;
    tick();
    check_eq("byte_store", dram_rd_data, 32'hAA22CC44);

    // Same-cycle write and read of one word is write-first.
    dram_wr_addr = 32'h10;
    dram_wr_data = 32'hDEADBEEF;
    dram_wr_byte_en = 4'hF;
    dram_rd_addr = 32'h10;
    tick();
    check_eq("write_first", dram_rd_data, 32'hDEADBEEF);

    // Out-of-range write dropped, out-of-range read returns 0.
    w0 = dref[0];
    dram_wr_addr = 32'h1000;
    dram_wr_data = ~w0;
    dram_wr_byte_en = 4'hF;
    dram_rd_addr = 32'h1000;
    iram_rd_addr = 32'h1000;
    tick();
    check_eq("oor_dram_read", dram_rd_data, 32'h0);
    check_eq("oor_iram_read", iram_rd_data, 32'h0);
    quiet();
    tick();
    check_eq("oor_write_dropped", dram_rd_data, w0);

    // Zero-length load.
    run_load(1'b1, 0, 100, -1);

    // DRAM len 4, gapped valid, reset after two beats.
    d2 = dref[2];
    d3 = dref[3];
    for (int i = 0; i < 4; i++) w[i] = $urandom;
    word_q = '{w[0], w[1], w[2], w[3]};
    run_load(1'b1, 4, 50, 2);
    check_eq("abort_core_rst_n", 32'(core_rst_n), 32'h1);
    quiet();
    for (int i = 0; i < 4; i++) begin
      dram_rd_addr = 32'(i * 4);
      tick();
      check_eq("abort_word", dram_rd_data, (i == 0) ? w[0] : (i == 1) ? w[1] : (i == 2) ? d2 : d3);
    end

    // Checksum wraps: 0xFFFFFFFF + 0x2.
    word_q = '{32'hFFFFFFFF, 32'h2};
    run_load(1'b1, 2, 100, -1);
`ifdef HXD32_MEM_CHKSUM_EN
    check_eq("sum_wrap", ld_sum, 32'h1);
`else
    check_eq("sum_tied_zero", ld_sum, 32'h0);
`endif

    // Randomized loads interleaved with core traffic.
    for (int k = 0; k < 20; k++) begin
      run_load(1'($urandom_range(0, 1)), int'($urandom_range(0, 40)),
               int'($urandom_range(30, 100)), -1);
      idle_cycles(int'($urandom_range(5, 50)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
